sevseg_scan_decoder: RTL

//   Samples a multiplexed, active-low seven-segment display bus (one segment bus, one-hot active-low digit selects).

---
 rtl/sevseg_pkg.sv | 25 ++
 rtl/sevseg_decode.sv | 32 +++
 rtl/sevseg_scan_decoder.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/sevseg_pkg.sv
// Seven-segment pattern table and code constants shared by the display
// encoders and the scan decoder.
package sevseg_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] CODE_BLANK = 4'hF;
    localparam logic [3:0] CODE_ERR   = 4'hE;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } evt_state_e;

endpackage

// File: rtl/sevseg_decode.sv
// Active-low seven-segment pattern back to BCD; inverse of the encoder table.
module sevseg_decode
    import sevseg_pkg::*;
(
    input  logic [6:0] seg_n,
    output logic       ok,
    output logic [3:0] code
);

    always_comb begin
        ok   = 1'b1;
        code = CODE_ERR;
        case (seg_n)
            SEG_0:     code = 4'd0;
            SEG_1:     code = 4'd1;
            SEG_2:     code = 4'd2;
            SEG_3:     code = 4'd3;
            SEG_4:     code = 4'd4;
            SEG_5:     code = 4'd5;
            SEG_6:     code = 4'd6;
            SEG_7:     code = 4'd7;
            SEG_8:     code = 4'd8;
            SEG_9:     code = 4'd9;
            SEG_BLANK: code = CODE_BLANK;
            default: begin
                code = CODE_ERR;
                ok   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/sevseg_scan_decoder.sv
// Samples a multiplexed seven-segment bus, debounces each digit and reports
// committed changes as valid/ready events.
module sevseg_scan_decoder
    import sevseg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int STABLE_CNT = 8,
    parameter int IDX_W      = $clog2(NUM_DIGITS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg_n,
    input  logic [NUM_DIGITS-1:0]   dig_n,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic [NUM_DIGITS-1:0]   digit_ok,
    output logic                    upd_valid,
    input  logic                    upd_ready,
    output logic [IDX_W-1:0]        upd_idx,
    output logic [3:0]              upd_bcd
);

    localparam int CNT_W = $clog2(STABLE_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT);
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(STABLE_CNT - 1);

    logic [6:0]              seg_s1_q, seg_s1_d, seg_s2_q, seg_s2_d;
    logic [NUM_DIGITS-1:0]   dig_s1_q, dig_s1_d, dig_s2_q, dig_s2_d;
    logic [3:0]              cand_q [NUM_DIGITS];
    logic [3:0]              cand_d [NUM_DIGITS];
    logic [CNT_W-1:0]        cnt_q  [NUM_DIGITS];
    logic [CNT_W-1:0]        cnt_d  [NUM_DIGITS];
    logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d;
    logic [NUM_DIGITS-1:0]   ok_q, ok_d;
    logic [NUM_DIGITS-1:0]   dirty_q, dirty_d;
    logic [NUM_DIGITS-1:0]   commit, clr;

    logic                    dec_ok;
    logic [3:0]              dec_code;
    logic                    seen_one, seen_multi, sample_ok;
    logic [IDX_W-1:0]        sel;
    logic                    any_dirty, load;
    logic [IDX_W-1:0]        pick_idx;
    logic [3:0]              pick_bcd;

    evt_state_e              state_q;
    logic                    upd_valid_q;
    logic [IDX_W-1:0]        upd_idx_q;
    logic [3:0]              upd_bcd_q;

    sevseg_decode u_decode (
        .seg_n (seg_s2_q),
        .ok    (dec_ok),
        .code  (dec_code)
    );

    always_comb begin
        seg_s1_d = seg_n;
        seg_s2_d = seg_s1_q;
        dig_s1_d = dig_n;
        dig_s2_d = dig_s1_q;
    end

    // A sample counts only when exactly one digit select is low.
    always_comb begin
        seen_one   = 1'b0;
        seen_multi = 1'b0;
        sel        = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!dig_s2_q[i]) begin
                seen_multi = seen_multi | seen_one;
                seen_one   = 1'b1;
                sel        = IDX_W'(i);
            end
        end
        sample_ok = seen_one & ~seen_multi;
    end

    always_comb begin
        bcd_d  = bcd_q;
        ok_d   = ok_q;
        commit = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            cand_d[i] = cand_q[i];
            cnt_d[i]  = cnt_q[i];
            if (sample_ok && sel == IDX_W'(i)) begin
                if (dec_code == cand_q[i]) begin
                    if (cnt_q[i] != CNT_MAX)
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    if (cnt_q[i] == CNT_PRE &&
                        (dec_code != bcd_q[4*i +: 4] || dec_ok != ok_q[i])) begin
                        bcd_d[4*i +: 4] = dec_code;
                        ok_d[i]         = dec_ok;
                        commit[i]       = 1'b1;
                    end
                end else begin
                    cand_d[i] = dec_code;
                    cnt_d[i]  = CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        any_dirty = 1'b0;
        pick_idx  = '0;
        pick_bcd  = CODE_BLANK;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (dirty_q[i]) begin
                any_dirty = 1'b1;
                pick_idx  = IDX_W'(i);
                pick_bcd  = bcd_q[4*i +: 4];
            end
        end
        load = any_dirty && (state_q == ST_IDLE || upd_ready);
        clr  = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (load && pick_idx == IDX_W'(i))
                clr[i] = 1'b1;
        // A fresh commit outranks the clear of the same digit.
        dirty_d = (dirty_q & ~clr) | commit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_s1_q <= '1;
            seg_s2_q <= '1;
            dig_s1_q <= '1;
            dig_s2_q <= '1;
            bcd_q    <= '1;
            ok_q     <= '1;
            dirty_q  <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                cand_q[i] <= CODE_BLANK;
                cnt_q[i]  <= '0;
            end
        end else begin
            seg_s1_q <= seg_s1_d;
            seg_s2_q <= seg_s2_d;
            dig_s1_q <= dig_s1_d;
            dig_s2_q <= dig_s2_d;
            bcd_q    <= bcd_d;
            ok_q     <= ok_d;
            dirty_q  <= dirty_d;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                cand_q[i] <= cand_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            upd_valid_q <= 1'b0;
            upd_idx_q   <= '0;
            upd_bcd_q   <= CODE_BLANK;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (load) begin
                        upd_idx_q   <= pick_idx;
                        upd_bcd_q   <= pick_bcd;
                        upd_valid_q <= 1'b1;
                        state_q     <= ST_PEND;
                    end
                end
                ST_PEND: begin
                    if (upd_ready) begin
                        if (load) begin
                            upd_idx_q <= pick_idx;
                            upd_bcd_q <= pick_bcd;
                        end else begin
                            upd_valid_q <= 1'b0;
                            state_q     <= ST_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    assign bcd_out   = bcd_q;
    assign digit_ok  = ok_q;
    assign upd_valid = upd_valid_q;
    assign upd_idx   = upd_idx_q;
    assign upd_bcd   = upd_bcd_q;

endmodule
